// File: rtl/mac_seq_3bit.sv
// Sequential A*B + C*C: one shift-and-add accumulator, time-shared between the
// A*B partial products and the C*C partial products, under a start/done handshake.
module mac_seq_3bit #(
  parameter int N = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic [N-1:0]   C,
  output logic           busy,
  output logic           done,
  output logic [2*N:0]   P
);
  localparam int W  = 2*N + 1;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MAB, MCC} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   ra, rb, rc;
  logic [W-1:0]   acc, addend, sum;
  logic [CW-1:0]  cnt;
  logic           last;

  assign last = (cnt == CW'(N-1));
  assign sum  = acc + addend;
  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Both multiply phases share the adder; only the partial-product source changes.
  always_comb begin
    state_nxt = state;
    addend    = '0;
    case (state)
      IDLE: if (start) state_nxt = MAB;
      MAB: begin
        if (rb[cnt]) addend = W'(ra) << cnt;
        if (last) state_nxt = MCC;
      end
      MCC: begin
        if (rc[cnt]) addend = W'(rc) << cnt;
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ra   <= '0;
      rb   <= '0;
      rc   <= '0;
      acc  <= '0;
      cnt  <= '0;
      P    <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ra  <= A;
          rb  <= B;
          rc  <= C;
          acc <= '0;
          cnt <= '0;
        end
        MAB: begin
          acc <= sum;
          cnt <= last ? '0 : cnt + 1'b1;
        end
        MCC: begin
          acc <= sum;
          if (last) begin
            cnt  <= '0;
            P    <= sum;
            done <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
